dkjr_input_cond: RTL and testbench

Player-input conditioner between the HPS joystick words and the `dkongjr_top` control inputs. It synchronises and debounces both joysticks, resolves opposing directions per player by last-pressed-wins, and merges the start buttons. It converts coin presses into fixed-width, queued, pause-aware coin pulses, so the game CPU never misses or double-counts a coin.

---
 rtl/dkjr_input_cond.sv | 176 +++++++++++++++++
 tb/tb_dkjr_input_cond.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dkjr_input_cond.sv
// rtl/dkjr_input_cond.sv - joystick sync/debounce, SOCD resolve, start merge and queued coin pulser
module dkjr_input_cond #(
    parameter int DEB_CYCLES      = 24576,
    parameter int COIN_LOW_CYCLES = 2457600,
    parameter int COIN_GAP_CYCLES = 2457600
) (
    input  logic       I_CLK_24576M,
    input  logic       I_RESETn,
    input  logic [7:0] I_JOY0,
    input  logic [7:0] I_JOY1,
    input  logic       I_PAUSE,
    output logic       O_U1n,
    output logic       O_D1n,
    output logic       O_L1n,
    output logic       O_R1n,
    output logic       O_J1n,
    output logic       O_U2n,
    output logic       O_D2n,
    output logic       O_L2n,
    output logic       O_R2n,
    output logic       O_J2n,
    output logic       O_S1n,
    output logic       O_S2n,
    output logic       O_C1n,
    output logic [2:0] O_COIN_PENDING
);
    localparam int PW   = $clog2(DEB_CYCLES);
    localparam int CMAX = (COIN_LOW_CYCLES > COIN_GAP_CYCLES) ? COIN_LOW_CYCLES : COIN_GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [15:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [15:0]   samp_q, samp_d, deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    last_h_q, last_h_d, last_v_q, last_v_d;
    logic [7:0]    dir_n_q, dir_n_d;
    logic [1:0]    jmp_n_q, jmp_n_d, start_n_q, start_n_d;
    logic          c1n_q, c1n_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic [2:0]    pending_q, pending_d;
    logic          tick, coin_edge, dec;
    logic [15:0]   same;

    // Last-pressed tracker: 01 = first direction of the pair, 10 = second, 00 = none.
    function automatic logic [1:0] socd_last(input logic rise_a, input logic rise_b,
                                              input logic [1:0] cur);
        if (rise_a && rise_b)
            return 2'b00;
        else if (rise_a)
            return 2'b01;
        else if (rise_b)
            return 2'b10;
        return cur;
    endfunction

    always_comb begin
        sync1_d    = {I_JOY1, I_JOY0};
        sync2_d    = sync1_q;
        tick       = (pre_q == PW'(DEB_CYCLES - 1));
        pre_d      = tick ? '0 : pre_q + PW'(1);
        same       = ~(sync2_q ^ samp_q);
        samp_d     = tick ? sync2_q : samp_q;
        deb_d      = tick ? ((deb_q & ~same) | (sync2_q & same)) : deb_q;
        deb_prev_d = deb_q;
        last_h_d   = last_h_q;
        last_v_d   = last_v_q;
        dir_n_d    = dir_n_q;
        jmp_n_d    = jmp_n_q;
        for (int p = 0; p < 2; p++) begin
            last_h_d[2*p +: 2] = socd_last(deb_q[8*p] & ~deb_prev_q[8*p],
                                           deb_q[8*p+1] & ~deb_prev_q[8*p+1], last_h_q[2*p +: 2]);
            last_v_d[2*p +: 2] = socd_last(deb_q[8*p+2] & ~deb_prev_q[8*p+2],
                                           deb_q[8*p+3] & ~deb_prev_q[8*p+3], last_v_q[2*p +: 2]);
            if (deb_q[8*p] && deb_q[8*p+1])
                dir_n_d[4*p +: 2] = ~last_h_d[2*p +: 2];
            else
                dir_n_d[4*p +: 2] = ~deb_q[8*p +: 2];
            if (deb_q[8*p+2] && deb_q[8*p+3])
                dir_n_d[4*p+2 +: 2] = ~last_v_d[2*p +: 2];
            else
                dir_n_d[4*p+2 +: 2] = ~deb_q[8*p+2 +: 2];
            jmp_n_d[p] = ~deb_q[8*p+4];
        end
        start_n_d[0] = ~(deb_q[5] | deb_q[13]);
        start_n_d[1] = ~(deb_q[6] | deb_q[14]);
    end

    // Coin engine: pause freezes state and counter, but edges keep queueing.
    always_comb begin
        coin_edge = (deb_q[7] | deb_q[15]) & ~(deb_prev_q[7] | deb_prev_q[15]);
        state_d   = state_q;
        ccnt_d    = ccnt_q;
        dec       = 1'b0;
        if (!I_PAUSE) begin
            case (state_q)
                ST_IDLE: if (pending_q != 3'd0) begin
                    state_d = ST_PULSE;
                    ccnt_d  = CW'(COIN_LOW_CYCLES - 1);
                    dec     = 1'b1;
                end
                ST_PULSE: if (ccnt_q == '0) begin
                    state_d = ST_GAP;
                    ccnt_d  = CW'(COIN_GAP_CYCLES - 1);
                end else begin
                    ccnt_d = ccnt_q - CW'(1);
                end
                ST_GAP: if (ccnt_q == '0)
                    state_d = ST_IDLE;
                else
                    ccnt_d = ccnt_q - CW'(1);
                default: state_d = ST_IDLE;
            endcase
        end
        pending_d = pending_q;
        if (coin_edge && !dec && pending_q != 3'd7)
            pending_d = pending_q + 3'd1;
        else if (dec && !coin_edge)
            pending_d = pending_q - 3'd1;
        c1n_d = (state_d != ST_PULSE);
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            samp_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            pre_q      <= '0;
            last_h_q   <= '0;
            last_v_q   <= '0;
            dir_n_q    <= '1;
            jmp_n_q    <= '1;
            start_n_q  <= '1;
            c1n_q      <= 1'b1;
            state_q    <= ST_IDLE;
            ccnt_q     <= '0;
            pending_q  <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            samp_q     <= samp_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            pre_q      <= pre_d;
            last_h_q   <= last_h_d;
            last_v_q   <= last_v_d;
            dir_n_q    <= dir_n_d;
            jmp_n_q    <= jmp_n_d;
            start_n_q  <= start_n_d;
            c1n_q      <= c1n_d;
            state_q    <= state_d;
            ccnt_q     <= ccnt_d;
            pending_q  <= pending_d;
        end
    end

    assign O_R1n          = dir_n_q[0];
    assign O_L1n          = dir_n_q[1];
    assign O_D1n          = dir_n_q[2];
    assign O_U1n          = dir_n_q[3];
    assign O_R2n          = dir_n_q[4];
    assign O_L2n          = dir_n_q[5];
    assign O_D2n          = dir_n_q[6];
    assign O_U2n          = dir_n_q[7];
    assign O_J1n          = jmp_n_q[0];
    assign O_J2n          = jmp_n_q[1];
    assign O_S1n          = start_n_q[0];
    assign O_S2n          = start_n_q[1];
    assign O_C1n          = c1n_q;
    assign O_COIN_PENDING = pending_q;
endmodule

// File: tb/tb_dkjr_input_cond.sv
// tb/tb_dkjr_input_cond.sv - directed self-checking bench for dkjr_input_cond
module tb_dkjr_input_cond;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] joy0, joy1;
    logic       pause;
    logic       u1n, d1n, l1n, r1n, j1n, u2n, d2n, l2n, r2n, j2n, s1n, s2n, c1n;
    logic [2:0] pend;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int falls[$];
    int rises[$];
    logic prev_c1n = 1'b1;

    dkjr_input_cond #(.DEB_CYCLES(4), .COIN_LOW_CYCLES(8), .COIN_GAP_CYCLES(6)) dut (
        .I_CLK_24576M(clk), .I_RESETn(rst_n), .I_JOY0(joy0), .I_JOY1(joy1), .I_PAUSE(pause),
        .O_U1n(u1n), .O_D1n(d1n), .O_L1n(l1n), .O_R1n(r1n), .O_J1n(j1n),
        .O_U2n(u2n), .O_D2n(d2n), .O_L2n(l2n), .O_R2n(r2n), .O_J2n(j2n),
        .O_S1n(s1n), .O_S2n(s2n), .O_C1n(c1n), .O_COIN_PENDING(pend)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_c1n === 1'b1 && c1n === 1'b0) falls.push_back(cyc);
        if (prev_c1n === 1'b0 && c1n === 1'b1) rises.push_back(cyc);
        prev_c1n = c1n;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {u1n, d1n, l1n, r1n, j1n, u2n, d2n, l2n, r2n, j2n, s1n, s2n, c1n};
    endfunction

    task automatic wait_fall(input string tag, output int found);
        int base;
        base  = falls.size();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1);
            if (c1n === 1'b0 && falls.size() > base) found = 1;
        end
        check(tag, found, 1);
    endtask

    initial begin
        int lat, seen, fb, rb, ok, found, nf;
        rst_n = 1'b0; joy0 = '0; joy1 = '0; pause = 1'b0;
        step(3);
        check("reset_outs", all_outs(), 13'h1fff);
        check("reset_pending", pend, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (all_outs() !== 13'h1fff || pend !== 3'd0) seen = 1;
        end
        check("idle_hold_100", seen, 0);

        joy0[4] = 1'b1;
        lat = 0;
        for (int n = 1; n <= 15; n++) begin
            step(1);
            if (j1n === 1'b0 && lat == 0) lat = n;
        end
        step(5);
        check("jump_latency_7_to_11", (lat >= 7 && lat <= 11), 1);
        joy0[4] = 1'b0;
        step(20);
        check("jump_release", j1n, 1);
        joy0[4] = 1'b1;
        step(3);
        joy0[4] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (j1n === 1'b0) seen = 1;
        end
        check("jump_glitch_blocked", seen, 0);

        joy0[0] = 1'b1; step(40);
        check("r_only_r", r1n, 0);
        check("r_only_l", l1n, 1);
        joy0[1] = 1'b1; step(40);
        check("l_last_l", l1n, 0);
        check("l_last_r", r1n, 1);
        joy0[1] = 1'b0; step(40);
        check("l_release_r", r1n, 0);
        check("l_release_l", l1n, 1);
        joy0[0] = 1'b0; step(40);
        joy0[1:0] = 2'b11; step(40);
        check("simul_rl_r", r1n, 1);
        check("simul_rl_l", l1n, 1);
        joy0[1:0] = 2'b00;
        joy1[2] = 1'b1; step(40);
        joy1[3] = 1'b1; step(40);
        check("p2_u_last_u", u2n, 0);
        check("p2_u_last_d", d2n, 1);
        joy1[5] = 1'b1; step(40);
        check("start1_from_p2", s1n, 0);
        check("start2_idle", s2n, 1);
        joy1 = '0; step(40);

        fb = falls.size(); rb = rises.size();
        for (int k = 0; k < 3; k++) begin
            joy0[7] = 1'b1; step(10);
            joy0[7] = 1'b0; step(10);
        end
        step(60);
        check("coin3_pulses", falls.size() - fb, 3);
        ok = (falls.size() - fb == 3) && (rises.size() - rb == 3);
        for (int i = 0; i < 3 && ok != 0; i++) begin
            if (rises[rb+i] - falls[fb+i] != 8) ok = 0;
            if (i < 2 && falls[fb+i+1] - rises[rb+i] < 6) ok = 0;
        end
        check("coin3_width8_gap6", ok, 1);
        check("coin3_pending_drained", pend, 0);

        fb = falls.size(); rb = rises.size();
        joy0[7] = 1'b1; step(10);
        joy0[7] = 1'b0;
        wait_fall("pause_first_fall", found);
        step(3);
        pause = 1'b1;
        step(3);
        joy1[7] = 1'b1;
        step(7);
        pause = 1'b0;
        step(4);
        check("pause_coin_queued", pend, 1);
        step(3);
        joy1[7] = 1'b0;
        step(40);
        nf = falls.size() - fb;
        check("pause_two_pulses", nf, 2);
        if (nf == 2 && rises.size() - rb >= 2) begin
            check("pause_width18", rises[rb] - falls[fb], 18);
            check("queued_width8", rises[rb+1] - falls[fb+1], 8);
        end
        check("pause_pending_drained", pend, 0);

        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            joy0[7] = 1'b1; step(8);
            joy0[7] = 1'b0; step(8);
        end
        step(12);
        check("pending_saturate7", pend, 7);
        check("paused_idle_no_pulse", c1n, 1);
        pause = 1'b0;
        wait_fall("sat_first_fall", found);
        step(3);
        rst_n = 1'b0;
        #1;
        check("reset_async_c1n", c1n, 1);
        check("reset_async_pending", pend, 0);
        step(2);
        rst_n = 1'b1;
        fb = falls.size();
        step(60);
        check("no_pulse_after_reset", falls.size() - fb, 0);
        check("c1n_high_after_reset", c1n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
